btb_param: RTL
==============

# btb_param

Parametrised direct-mapped branch target buffer with 2-bit saturating direction counters, tag match, flush and mispredict detection. Sits beside the fetch stage of the pipelined core: the IF stage looks up `fetch_pc` combinationally for a predicted next PC. The EX stage resolves branches against the flags, updates the table, and raises a redirect when the carried prediction was wrong.

## Interface
- `PC_W`, 16: PC width.
- `INDEX_W`, 4: index bits; `ENTRIES = 2**INDEX_W`; tag is `fetch_pc[PC_W-1:INDEX_W]`.
- `BR_OPCODE`, 4'b1001: opcode of conditional branch.
- `CNT_W`, 16: width of mispredict counter.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `fetch_pc`  in  PC_W  PC being fetched.
- `btb_hit`  out  1  entry valid and tag matches `fetch_pc`.
- `btb_prediction`  out  1  predict taken: `btb_hit & ctr[1]`.
- `btb_target`  out  PC_W  stored target if `btb_prediction`, else `fetch_pc + 1`.
- `ex_valid`  in  1  EX stage holds a valid instruction.
- `ex_pc`  in  PC_W  PC of EX instruction.
- `ex_opcode`  in  4  opcode of EX instruction.
- `ex_cond`  in  3  condition mask `{g,z,l}`.
- `gflag`, `zflag`, `lflag`  in  1 each  ALU flags for EX branch.
- `target_entry`  in  PC_W  resolved branch target.
- `ex_pred`  in  1  `btb_prediction` carried from fetch.
- `ex_pred_target`  in  PC_W  `btb_target` carried from fetch.
- `flush`  in  1  invalidate all entries.
- `ex_mispredict`  out  1  redirect required this cycle.
- `ex_redirect_pc`  out  PC_W  correct next PC when `ex_mispredict`.
- `mispredict_count`  out  CNT_W  saturating mispredict count.

## Operation
- Per entry state: `valid`, `tag` (PC_W-INDEX_W), `target` (PC_W), `ctr` (2 bits).
- Lookup is combinational on `fetch_pc`. Index is `fetch_pc[INDEX_W-1:0]`.
- `is_br = ex_valid & (ex_opcode == BR_OPCODE)`.
- `taken = is_br & |(ex_cond & {gflag,zflag,lflag})`. A mask of 3'b000 is never taken.
- `ex_hit` is the tag match at `ex_pc` index.
- Update on branch hit:
  - `ctr` increments if taken, saturating at 3.
  - `ctr` decrements if not taken, saturating at 0.
  - If taken, `target <= target_entry`.
- Update on branch miss:
  - If taken, allocate/overwrite the entry: `valid=1`, tag, `target=target_entry`, `ctr=2'b10`.
  - If not taken, there is no allocation.
- Non-branch with `ex_valid & ex_pred` (alias/stale entry): the entry at `ex_pc` index is invalidated if `ex_hit`.
- Mispredict:
  - `ex_mispredict = ex_valid & ((is_br & (taken != ex_pred)) | (taken & ex_pred & ex_pred_target != target_entry) | (!is_br & ex_pred))`.
  - `ex_redirect_pc = taken ? target_entry : ex_pc + 1`.
- `mispredict_count` increments on every cycle with `ex_mispredict`. It saturates at all-ones and is cleared only by reset.
- `flush` clears all `valid` bits at the edge. It has priority over a same-cycle update, so no allocation occurs. `ctr` and `target` are untouched.
- PC arithmetic is modulo 2^PC_W: `16'hFFFF + 1 = 0`.

## Timing
- Reset (`rst` low, asynchronous):
  - All `valid=0`, `ctr=2'b01`, `target=0`, `mispredict_count=0`.
  - Outputs settle to `btb_hit=0`, `btb_prediction=0`, `btb_target=fetch_pc+1`.
- Reset deasserted mid-operation: the table is empty and the count is 0; the first edge after release may update.
- Lookup latency is 0 cycles (combinational). An update is visible to lookup from the cycle after the edge.
- Same-cycle update and lookup of the same index: fetch sees the pre-update value; there is no bypass.
- `ex_mispredict` and `ex_redirect_pc` are combinational in the EX cycle. Counter and table update at the same edge.
- Fetch and EX indices colliding with different tags: the update writes, and the fetch result uses the old contents.

## Test plan
- Reset then `fetch_pc` 0..15 -> `btb_hit=0`, `btb_target=fetch_pc+1`, `mispredict_count=0`.
- Branch at `ex_pc=2`, `ex_cond=3'b010`, `zflag=1`, `target_entry=16'h0040`, `ex_pred=0` -> `ex_mispredict=1`, `ex_redirect_pc=16'h0040`, count=1. Next cycle `fetch_pc=2` -> hit, predict taken, target 16'h0040.
- Same branch not taken three times in a row -> `ctr` 2→1→0→0 (saturation); prediction drops after the first. `ex_redirect_pc=3` whenever `ex_pred=1`.
- Aliasing: entry allocated for `ex_pc=16'h0002`; fetch `16'h0012` -> `btb_hit=0`. Non-branch at `16'h0002` with `ex_pred=1` -> mispredict, redirect 3, entry invalidated.
- `flush` asserted in the same cycle as a taken-branch allocate -> all entries invalid afterwards and no allocation occurs.
- Force `mispredict_count` to 16'hFFFF via repeated mispredicts (or `CNT_W=2` build) -> holds at max. Async `rst` low mid-stream clears the count and table without waiting for a clock edge.

Source files
------------

// File: rtl/btb_param_if.sv
// Fetch-lookup and EX-resolve signal bundle between the core and the branch target buffer.
// master = core side (drives PCs/flags), slave = BTB side (drives predictions and redirect).
interface btb_param_if #(
    parameter int PC_W  = 16,
    parameter int CNT_W = 16
);
    logic [PC_W-1:0]  fetch_pc;
    logic             btb_hit;
    logic             btb_prediction;
    logic [PC_W-1:0]  btb_target;
    logic             ex_valid;
    logic [PC_W-1:0]  ex_pc;
    logic [3:0]       ex_opcode;
    logic [2:0]       ex_cond;
    logic             gflag;
    logic             zflag;
    logic             lflag;
    logic [PC_W-1:0]  target_entry;
    logic             ex_pred;
    logic [PC_W-1:0]  ex_pred_target;
    logic             flush;
    logic             ex_mispredict;
    logic [PC_W-1:0]  ex_redirect_pc;
    logic [CNT_W-1:0] mispredict_count;

    modport master (
        output fetch_pc, ex_valid, ex_pc, ex_opcode, ex_cond, gflag, zflag, lflag,
               target_entry, ex_pred, ex_pred_target, flush,
        input  btb_hit, btb_prediction, btb_target, ex_mispredict, ex_redirect_pc,
               mispredict_count
    );

    modport slave (
        input  fetch_pc, ex_valid, ex_pc, ex_opcode, ex_cond, gflag, zflag, lflag,
               target_entry, ex_pred, ex_pred_target, flush,
        output btb_hit, btb_prediction, btb_target, ex_mispredict, ex_redirect_pc,
               mispredict_count
    );
endinterface

// File: rtl/btb_param.sv
// Direct-mapped BTB with 2-bit direction counters: 0-cycle lookup, EX-resolved updates at the edge.
// No backpressure: lookup and resolve are accepted every cycle; flush beats any same-cycle update.
module btb_param #(
    parameter int         PC_W      = 16,
    parameter int         INDEX_W   = 4,
    parameter logic [3:0] BR_OPCODE = 4'b1001,
    parameter int         CNT_W     = 16
) (
    input  logic       clk,
    input  logic       rst,
    btb_param_if.slave bus
);
    localparam int ENTRIES = 2**INDEX_W;
    localparam int TAG_W   = PC_W - INDEX_W;

    logic              r_valid  [ENTRIES];
    logic [TAG_W-1:0]  r_tag    [ENTRIES];
    logic [PC_W-1:0]   r_target [ENTRIES];
    logic [1:0]        r_ctr    [ENTRIES];
    logic [CNT_W-1:0]  r_cnt;

    logic [INDEX_W-1:0] w_f_idx;
    logic [TAG_W-1:0]   w_f_tag;
    logic [INDEX_W-1:0] w_e_idx;
    logic [TAG_W-1:0]   w_e_tag;
    logic               w_f_hit;
    logic               w_f_pred;
    logic               w_e_hit;
    logic               w_is_br;
    logic               w_taken;
    logic               w_mispredict;

    assign w_f_idx  = bus.fetch_pc[INDEX_W-1:0];
    assign w_f_tag  = bus.fetch_pc[PC_W-1:INDEX_W];
    assign w_e_idx  = bus.ex_pc[INDEX_W-1:0];
    assign w_e_tag  = bus.ex_pc[PC_W-1:INDEX_W];

    // Lookup reads the pre-edge table contents; no bypass from a same-cycle update.
    assign w_f_hit  = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    assign w_f_pred = w_f_hit && r_ctr[w_f_idx][1];
    assign w_e_hit  = r_valid[w_e_idx] && (r_tag[w_e_idx] == w_e_tag);

    assign w_is_br  = bus.ex_valid && (bus.ex_opcode == BR_OPCODE);
    assign w_taken  = w_is_br && |(bus.ex_cond & {bus.gflag, bus.zflag, bus.lflag});

    assign w_mispredict = bus.ex_valid &&
                          ((w_is_br && (w_taken != bus.ex_pred)) ||
                           (w_taken && bus.ex_pred && (bus.ex_pred_target != bus.target_entry)) ||
                           (!w_is_br && bus.ex_pred));

    assign bus.btb_hit          = w_f_hit;
    assign bus.btb_prediction   = w_f_pred;
    assign bus.btb_target       = w_f_pred ? r_target[w_f_idx] : bus.fetch_pc + PC_W'(1);
    assign bus.ex_mispredict    = w_mispredict;
    assign bus.ex_redirect_pc   = w_taken ? bus.target_entry : bus.ex_pc + PC_W'(1);
    assign bus.mispredict_count = r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b01;
            end
        end else if (bus.flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
            end
        end else if (w_is_br) begin
            if (w_e_hit) begin
                if (w_taken) begin
                    r_target[w_e_idx] <= bus.target_entry;
                    if (r_ctr[w_e_idx] != 2'b11)
                        r_ctr[w_e_idx] <= r_ctr[w_e_idx] + 2'b01;
                end else if (r_ctr[w_e_idx] != 2'b00) begin
                    r_ctr[w_e_idx] <= r_ctr[w_e_idx] - 2'b01;
                end
            end else if (w_taken) begin
                r_valid[w_e_idx]  <= 1'b1;
                r_tag[w_e_idx]    <= w_e_tag;
                r_target[w_e_idx] <= bus.target_entry;
                r_ctr[w_e_idx]    <= 2'b10;
            end
        end else if (bus.ex_valid && bus.ex_pred && w_e_hit) begin
            // Fetch predicted a branch where EX found none: drop the stale/aliased entry.
            r_valid[w_e_idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_cnt <= '0;
        else if (w_mispredict && (r_cnt != '1))
            r_cnt <= r_cnt + CNT_W'(1);
    end
endmodule
